// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor: X - Y - B0, DIGIT bits per clock with borrow lookahead inside each
// slice and a registered borrow between slices. Optional macro SUB_BACK_TO_BACK_EN.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             B0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              b_q, b_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [DIGIT-1:0]  sx, sy, g, p, sd;
  logic [DIGIT:0]    c;
  logic              prod;
  logic [WIDTH-1:0]  acc_shift;

  // Slice borrows in lookahead form: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]b.
  always_comb begin
    sx   = x_q[DIGIT-1:0];
    sy   = y_q[DIGIT-1:0];
    g    = ~sx & sy;
    p    = ~(sx ^ sy);
    c    = '0;
    prod = 1'b0;
    c[0] = b_q;
    for (int i = 0; i < DIGIT; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & b_q);
    end
    sd = sx ^ sy ^ c[DIGIT-1:0];
  end

`ifdef SUB_BACK_TO_BACK_EN
  assign in_ready = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
`else
  assign in_ready = ~rst & (state_q == StIdle);
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    diff_d    = diff_q;
    b_d       = b_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    acc_shift = acc_q >> DIGIT;
    acc_shift[WIDTH-1 -: DIGIT] = sd;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          x_d     = X;
          y_d     = Y;
          b_d     = B0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d   = x_q >> DIGIT;
        y_d   = y_q >> DIGIT;
        acc_d = acc_shift;
        b_d   = c[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          diff_d  = acc_shift;
          bout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
`ifdef SUB_BACK_TO_BACK_EN
          if (in_valid) begin
            x_d     = X;
            y_d     = Y;
            b_d     = B0;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor; expected results come from integer arithmetic.
module tb_serial_borrow_subtractor;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned N     = WIDTH / DIGIT;
`ifdef SUB_BACK_TO_BACK_EN
  localparam int Interval = N + 1;
`else
  localparam int Interval = N + 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X, Y;
  logic             B0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   rise_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  logic ov_prev = 1'b0;

  serial_borrow_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .X          (X),
    .Y          (Y),
    .B0         (B0),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic b);
    exp_t m;
    int   ux, uy, sx, sy, u, s;
    ux = int'(x);
    uy = int'(y);
    sx = x[7] ? ux - 256 : ux;
    sy = y[7] ? uy - 256 : uy;
    u  = ux - uy - int'(b);
    s  = sx - sy - int'(b);
    m.d = 8'((u + 256) % 256);
    m.b = (u < 0);
    m.o = (s < -128) || (s > 127);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got diff %0h, expected no result", diff);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow_out", 32'(borrow_out), 32'(e.b));
        check("overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise_q.push_back(cyc);
    ov_prev = out_valid;
  end

  // Sole driver of out_ready: 0 = stall, 1 = always ready, 2 = random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) out_ready = 1'b0;
      else if (bp_mode == 1) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic b);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    X  = x;
    Y  = y;
    B0 = b;
    n  = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(x, y, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X  = 8'($urandom);
        Y  = 8'($urandom);
        B0 = 1'($urandom_range(0, 1));
        return;
      end
      n++;
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected accept", n);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    rst = 1'b1;
    in_valid = 1'b0;
    X = '0;
    Y = '0;
    B0 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_borrow", 32'(borrow_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 1);

    // Latency: out_valid rises exactly N edges after the accept edge.
    send(8'h50, 8'h20, 1'b0);
    for (int k = 0; k <= int'(N); k++) begin
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'(k == int'(N)));
    end

    // Backpressure: result held, busy input not accepted.
    e0 = model(8'h50, 8'h20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      X  = 8'h11;
      Y  = 8'h11;
      B0 = 1'b0;
      @(negedge clk);
      check("hold_diff", 32'(diff), 32'(e0.d));
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    bp_mode = 1;
    send(8'h11, 8'h11, 1'b0);
    send(8'h20, 8'h50, 1'b0);
    send(8'h00, 8'h00, 1'b1);
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'hFF, 1'b0);
    drain();

    // Reset two cycles into RUN discards the transaction immediately.
    send(8'h50, 8'h20, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    q.delete();
    #1;
    check("midrun_out_valid", 32'(out_valid), 0);
    check("midrun_diff", 32'(diff), 0);
    check("midrun_borrow", 32'(borrow_out), 0);
    check("midrun_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_midrun", 32'(in_ready), 1);
    send(8'h09, 8'h03, 1'b1);
    drain();

    // Streaming issue interval.
    rise_q.delete();
    send(8'h50, 8'h20, 1'b0);
    send(8'h20, 8'h50, 1'b0);
    send(8'h80, 8'h01, 1'b0);
    drain();
    check("stream_results", 32'(rise_q.size()), 3);
    if (rise_q.size() == 3) begin
      check("interval_1", 32'(rise_q[1] - rise_q[0]), 32'(Interval));
      check("interval_2", 32'(rise_q[2] - rise_q[1]), 32'(Interval));
    end

    // Random operands under random backpressure.
    bp_mode = 2;
    for (int t = 0; t < 40; t++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    bp_mode = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Multi-cycle subtractor, the subtract counterpart of the team's 8-bit carry lookahead adder.
- Computes X - Y - B0 one DIGIT-bit slice per clock, using borrow-lookahead inside each slice.
- The borrow ripples between slices through a register.
- Sits behind a valid/ready handshake on both sides so datapath blocks can issue subtracts and absorb backpressure.

Parameters:
- WIDTH, 8: operand and result width in bits.
- DIGIT, 2: bits processed per clock. WIDTH must be a multiple of DIGIT; N = WIDTH/DIGIT is the number of RUN cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- X  input  WIDTH  minuend.
- Y  input  WIDTH  subtrahend.
- B0  input  1  borrow in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  X - Y - B0, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when X < Y + B0 (unsigned).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asynchronous, takes effect at once, including mid-RUN or in DONE):
  - state = IDLE; operand, result and borrow registers and the slice counter cleared.
  - Outputs: out_valid=0, diff=0, borrow_out=0, overflow=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
  - A transaction in flight is discarded; nothing is emitted for it.
- in_ready = (state==IDLE) & ~rst. It is a combinational decode of state; the input side has no combinational path to the output side.
- IDLE:
  - Acceptance occurs when in_valid & in_ready at a rising edge.
  - On acceptance, register X, Y and B0 (B0 into the borrow register), clear the counter, and go to RUN.
- RUN, one slice per cycle on the low DIGIT bits of the X/Y shift registers:
  - Per bit: g = ~x & y; p = ~(x ^ y); d = x ^ y ^ b; b_next = g | (p & b).
  - Borrows within a slice use lookahead form, not a chain of b_next.
  - Shift X and Y right by DIGIT. Shift the slice's d bits into the top of the result register.
  - Store the slice's borrow-out in the borrow register.
  - In the final slice, also capture the borrow into the MSB, for overflow = borrow_into_msb ^ borrow_out_of_msb.
  - After the Nth slice, go to DONE.
- DONE:
  - out_valid=1; diff, borrow_out and overflow are registered and stable.
  - While out_ready=0: hold every output unchanged indefinitely; in_valid is ignored.
  - When out_ready=1 at a rising edge: the transfer completes, go to IDLE, and out_valid=0 next cycle.
  - diff, borrow_out and overflow keep their last values until the next result; only out_valid qualifies them.
- Latency:
  - Acceptance at edge E0 gives out_valid=1 after edge E0+N (N=4 at defaults).
  - Minimum issue interval is N+2 cycles without the optional feature.
- Boundary cases:
  - Operands are sampled only on the accept edge; later changes on X, Y or B0 have no effect.
  - in_valid while busy is not accepted, and the source holds it.
  - Zero operands with B0=1 wrap to all ones with borrow_out=1.
  - DIGIT=WIDTH degenerates to one RUN cycle and must still meet the handshake rules.

Optional Feature:
- Macro: SUB_BACK_TO_BACK_EN.
- Defined:
  - in_ready = ~rst & ((state==IDLE) | (state==DONE & out_ready)).
  - A simultaneous output transfer and input accept in DONE goes directly to RUN with the new operands.
  - Issue interval becomes N+1 cycles.
  - An output transfer in DONE with no in_valid goes to IDLE.
- Not defined: behaviour exactly as above; in_ready is high only in IDLE.

Test Plan:
- Defaults WIDTH=8, DIGIT=2. X=0x50, Y=0x20, B0=0 -> diff=0x30, borrow_out=0, overflow=0; out_valid rises exactly 4 cycles after accept.
- X=0x20, Y=0x50, B0=0 -> diff=0xD0, borrow_out=1, overflow=0. Then X=0x00, Y=0x00, B0=1 -> diff=0xFF, borrow_out=1, overflow=0.
- X=0x80, Y=0x01, B0=0 -> diff=0x7F, borrow_out=0, overflow=1. Then X=0x7F, Y=0xFF, B0=0 -> diff=0x80, borrow_out=1, overflow=1.
- Result X=0x50, Y=0x20 pending; hold out_ready=0 for 3 cycles while driving in_valid=1 with X=0x11, Y=0x11 -> diff stays 0x30, in_ready=0, nothing accepted. Raise out_ready -> transfer, then 0x11-0x11 accepted -> diff=0x00.
- Assert rst 2 cycles into RUN -> out_valid=0, diff=0 immediately. After deassert, in_ready=1; X=0x09, Y=0x03, B0=1 -> diff=0x05, borrow_out=0.
- With SUB_BACK_TO_BACK_EN: stream (0x50,0x20), (0x20,0x50), (0x80,0x01) with out_ready=1 -> results 0x30, 0xD0, 0x7F, out_valid edges 5 cycles apart. Without the macro -> 6 cycles apart.
